// File: rtl/branch_pkg.sv
// Shared types and constants for the LEGv8 branch-class control sequencer.
package branch_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LINK, S_EVAL, S_BRANCH, S_FALL, S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    CL_B, CL_BL, CL_CBZ, CL_CBNZ, CL_BCOND, CL_BR, CL_ILL
  } class_t;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_BUS  = 2'b11;

  localparam logic [4:0] FS_PASS_A = 5'b00000;
  localparam logic [4:0] FS_ORR    = 5'b00101;
  localparam logic [4:0] FS_NOP    = 5'b11111;
  localparam logic [4:0] XZR       = 5'd31;

  localparam logic [1:0] NS_DONE = 2'b00;
  localparam logic [1:0] NS_CONT = 2'b01;

  localparam int CW_W          = 33;
  localparam int CW_ALU_EN     = 32;
  localparam int CW_ALU_FS     = 26;
  localparam int CW_RF_SA      = 20;
  localparam int CW_RF_SB      = 15;
  localparam int CW_RF_DA      = 10;
  localparam int CW_RF_W       = 9;
  localparam int CW_PC_EN      = 6;
  localparam int CW_PC_FS      = 4;
  localparam int CW_NEXT_STATE = 0;

  typedef struct packed {
    logic       alu_en;
    logic       alu_bs;
    logic [4:0] alu_fs;
    logic       rf_b_en;
    logic [4:0] rf_sa;
    logic [4:0] rf_sb;
    logic [4:0] rf_da;
    logic       rf_w;
    logic       ram_en;
    logic       ram_w;
    logic       pc_en;
    logic [1:0] pc_fs;
    logic       pc_is;
    logic       status_ld;
    logic [1:0] next_state;
  } cw_t;

  localparam cw_t NOP_CW = '{
    alu_en: 1'b0, alu_bs: 1'b0, alu_fs: FS_NOP, rf_b_en: 1'b0,
    rf_sa: 5'd0, rf_sb: XZR, rf_da: 5'd0, rf_w: 1'b0,
    ram_en: 1'b0, ram_w: 1'b0, pc_en: 1'b0, pc_fs: PC_HOLD,
    pc_is: 1'b0, status_ld: 1'b0, next_state: NS_DONE
  };

  function automatic class_t decode_class(input logic [31:0] ins, input logic cond_en);
    if (ins[31:26] == OP_B)                  return CL_B;
    if (ins[31:26] == OP_BL)                 return CL_BL;
    if (ins[31:24] == OP_CBZ)                return CL_CBZ;
    if (ins[31:24] == OP_CBNZ)               return CL_CBNZ;
    if (ins[31:24] == OP_BCOND && cond_en)   return CL_BCOND;
    if (ins[31:21] == OP_BR)                 return CL_BR;
    return CL_ILL;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ARM condition-code evaluation of registered {N,Z,C,V} against a 4-bit cond field.
module branch_cond_eval (
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c && !z;
      4'h9:    pass = !c || z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z && (n == v);
      4'hD:    pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch sequencer: latches one branch per start, emits 1-2 registered
// control words, reports taken/illegal and counts taken branches with saturation.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int LINK_REG = 30,
  parameter bit COND_EN  = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              I,
  input  logic [4:0]               status,
  output logic [CW_W-1:0]          cw,
  output logic signed [DATA_W-1:0] K,
  output logic                     busy,
  output logic                     done,
  output logic                     taken,
  output logic                     illegal,
  output logic [CNT_W-1:0]         taken_count
);

  state_t                     state, nxt_state;
  class_t                     cls, dec_cls;
  logic                       cond_pass;
  logic                       accept;
  logic                       is_br;
  logic signed [DATA_W-1:0]   k_dec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic cw_t cw_for(input state_t s, input logic br,
                                 input logic [4:0] rn, input logic [4:0] rt);
    cw_t c;
    c = NOP_CW;
    case (s)
      S_LINK: begin
        c.rf_da      = 5'(LINK_REG);
        c.rf_w       = 1'b1;
        c.next_state = NS_CONT;
      end
      S_EVAL: begin
        c.rf_sa      = rt;
        c.rf_sb      = XZR;
        c.alu_fs     = FS_ORR;
        c.next_state = NS_CONT;
      end
      S_BRANCH: begin
        c.pc_en = 1'b1;
        if (br) begin
          c.alu_en = 1'b1;
          c.rf_sa  = rn;
          c.alu_fs = FS_PASS_A;
          c.pc_fs  = PC_BUS;
          c.pc_is  = 1'b1;
        end else begin
          c.pc_fs = PC_REL;
        end
      end
      S_FALL: begin
        c.pc_en = 1'b1;
        c.pc_fs = PC_INC;
      end
      default: c = NOP_CW;
    endcase
    return c;
  endfunction

  branch_cond_eval u_cond (
    .nzcv (status[3:0]),
    .cond (I[3:0]),
    .pass (cond_pass)
  );

  assign dec_cls = decode_class(I, COND_EN);
  assign accept  = (state == S_IDLE) && start;
  assign is_br   = accept && (dec_cls == CL_BR);
  assign k_dec   = (dec_cls == CL_B || dec_cls == CL_BL)
                   ? {{(DATA_W-26){I[25]}}, I[25:0]}
                   : {{(DATA_W-19){I[23]}}, I[23:5]};

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (dec_cls)
            CL_B, CL_BR:      nxt_state = S_BRANCH;
            CL_BL:            nxt_state = S_LINK;
            CL_CBZ, CL_CBNZ:  nxt_state = S_EVAL;
            CL_BCOND:         nxt_state = cond_pass ? S_BRANCH : S_FALL;
            default:          nxt_state = S_ILLEGAL;
          endcase
        end
      end
      S_LINK:  nxt_state = S_BRANCH;
      // Live ALU zero at the end of EVAL; CBZ branches on zero, CBNZ on non-zero.
      S_EVAL:  nxt_state = (status[4] == (cls == CL_CBZ)) ? S_BRANCH : S_FALL;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered alongside the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cls         <= CL_ILL;
      cw          <= NOP_CW;
      K           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      taken       <= 1'b0;
      illegal     <= 1'b0;
      taken_count <= '0;
    end else begin
      state   <= nxt_state;
      cw      <= cw_for(nxt_state, is_br, I[9:5], I[4:0]);
      busy    <= (nxt_state != S_IDLE);
      done    <= (nxt_state == S_BRANCH) || (nxt_state == S_FALL) || (nxt_state == S_ILLEGAL);
      taken   <= (nxt_state == S_BRANCH);
      illegal <= (nxt_state == S_ILLEGAL);
      if (nxt_state == S_BRANCH) taken_count <= sat_inc(taken_count);
      if (accept) begin
        cls <= dec_cls;
        K   <= k_dec;
      end
    end
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle branch-class control sequencer for the LEGv8 control unit. It generalises the single-cycle branch-register decoder to cover B, BL, BR, CBZ, CBNZ and B.cond. It latches one instruction per start handshake and steps through 1–2 control-word cycles. It also reports taken/not-taken and keeps a saturating taken-branch counter.

Parameters:
DATA_W, 64, datapath width; width of K.
LINK_REG, 30, register written by BL.
COND_EN, 1, 1 = B.cond supported; 0 = B.cond flagged illegal.
CNT_W, 16, width of the taken-branch counter.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high.
start  in  1  request; accepted only when busy=0.
I  in  32  instruction word; sampled on accepted start.
status  in  5  [4] live ALU zero; [3:0] registered {N,Z,C,V}.
cw  out  33  control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}.
K  out  DATA_W  sign-extended branch offset (word units) for the PC adder.
busy  out  1  high from accepted start until the done cycle.
done  out  1  one-cycle pulse on the final control-word cycle.
taken  out  1  valid with done; 1 = PC redirected.
illegal  out  1  one-cycle pulse when a latched opcode is not a supported branch.
taken_count  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: state IDLE; cw=NOP; K=0; busy, done, taken, illegal all 0; taken_count=0. Reset mid-sequence aborts with no further rf_w or pc_en.
- NOP word: all enables 0, alu_fs=11111, rf_sb=31, pc_fs=00, next_state=00.
- pc_fs encoding: 00 hold, 01 PC+4, 10 PC+4+(K<<2), 11 load databus. pc_is=1 selects databus.
- Decode on I[31:21] and store class in a register:
  - B: 000101x.
  - BL: 100101x.
  - CBZ / CBNZ: 10110100 / 10110101.
  - B.cond: 01010100.
  - BR: 11010110000.
- K sign-extension: imm26 from I[25:0] for B/BL; imm19 from I[23:5] otherwise. K is held constant while busy.
- Start in IDLE with start=1: latch I, busy=1 next cycle. start while busy is ignored.
- States:
  - IDLE: cw=NOP.
  - LINK (BL only): databus=PC+4, rf_da=LINK_REG, rf_w=1. Next state is BRANCH.
  - EVAL (CBZ/CBNZ): alu_en=0 (bus unused), rf_sa=Rt=I[4:0], alu_fs=ORR with B zero (rf_sb=31); status[4] is sampled at end of cycle. Next state is BRANCH or FALL per zero and polarity.
  - BRANCH: pc_en=1, pc_fs=10, done=1, taken=1.
    - For BR: alu_en=1, rf_sa=Rn=I[9:5], alu passes A, pc_fs=11, pc_is=1.
  - FALL: pc_en=1, pc_fs=01, done=1, taken=0.
  - ILLEGAL: NOP cw, done=1, illegal=1, taken=0.
- First step after start:
  - B and BR go to BRANCH.
  - BL goes to LINK.
  - CBZ/CBNZ go to EVAL.
  - B.cond goes to BRANCH if its condition on {N,Z,C,V} holds, else FALL. Standard ARM conditions 0x0–0xD apply; 0xE and 0xF mean always.
  - Anything else goes to ILLEGAL.
- From BRANCH, FALL or ILLEGAL the sequencer returns to IDLE; busy drops the same edge.
- Latency, start to done: 1 cycle for B/BR/B.cond/illegal, 2 for BL/CBZ/CBNZ. start may reassert in the cycle after done.
- status_ld=0 and ram_en=ram_w=0 in every state. next_state field=00 on done cycles, 01 otherwise.
- taken_count increments on done with taken=1. It saturates at all-ones and never wraps.

Decomposition:
- Shared package branch_pkg: state enum, branch class enum, opcode match constants, pc_fs codes, NOP control word constant, cw field offsets.
- One sub-module, branch_cond_eval: combinational {N,Z,C,V}+cond → pass.

Test Plan:
- B imm26=0x3FFFFFF (−1): start → next cycle K=all-ones, pc_fs=10, done=1, taken=1, taken_count=1.
- BL imm26=0x10: cycle 1 rf_w=1, rf_da=30; cycle 2 pc_fs=10, done=1; K=0x10.
- CBZ Rt=5 with status[4]=0 at EVAL, then CBNZ Rt=5 with status[4]=0 → each gives 2-cycle sequence; CBZ ends FALL (pc_fs=01, taken=0), CBNZ ends BRANCH (taken=1).
- B.cond: cond=GE(0xA) with N=1,V=0 → FALL; cond=LT(0xB) same flags → BRANCH; COND_EN=0 → illegal=1, cw=NOP.
- Opcode 0x000 → illegal pulse, done=1, no pc_en. Assert start while busy → ignored. Reset asserted during LINK → next cycle IDLE, cw=NOP, no pc_en.
- Force taken_count to all-ones minus 1 by issuing taken branches; two more B → count stays at all-ones.
